// File: rtl/btb_pkg.sv
// btb_pkg: types and constants shared by the btb access controller, its
// update FIFO and the btb array itself.
//   state_e   : controller state (RUN, FLUSH)
//   btb_upd_t : one resolved-branch update {pc, target, taken}
//   BTB_XLEN / BTB_ENTRIES / BTB_IDX_W : default PC width and table geometry
package btb_pkg;

    localparam int unsigned BTB_XLEN    = 32;
    localparam int unsigned BTB_ENTRIES = 16;
    localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic [BTB_XLEN-1:0] pc;
        logic [BTB_XLEN-1:0] target;
        logic                taken;
    } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: synchronous FIFO of btb_upd_t with occupancy output.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : discard all entries (wins over a same-cycle push/pop)
//   push_i, data_i : enqueue (caller guarantees not full)
//   pop_i, head_o  : dequeue / current head (caller guarantees not empty)
//   count_o        : number of queued entries, 0..DEPTH
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  btb_upd_t               data_i,
    input  logic                   pop_i,
    output btb_upd_t               head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    btb_upd_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/btb_access_ctrl.sv
// btb_access_ctrl: sequences the single-ported btb between fetch lookups,
// buffered commit-side updates and a full-table invalidate walk on flush.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   fetch_valid/fetch_pc/fetch_ready: prediction lookup request / grant
//   upd_valid/pc/target/taken/ready : resolved-branch update into the FIFO
//   flush_req / flush_busy          : start / progress of invalidate walk
//   branchPredict_en, PC            : btb lookup strobe and lookup/write PC
//   branchRecover_en, wr_target/taken: btb write strobe and data
//   inval_en, inval_idx             : btb invalidate strobe and entry
// Optional: define BTB_ACCESS_STAT_EN to add stat_lookups, stat_updates and
// stat_stalls counters.
module btb_access_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned XLEN      = BTB_XLEN,
    parameter int unsigned ENTRIES   = BTB_ENTRIES,
    parameter int unsigned UPD_DEPTH = 4,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fetch_valid,
    input  logic [XLEN-1:0]             fetch_pc,
    output logic                        fetch_ready,
    input  logic                        upd_valid,
    input  logic [XLEN-1:0]             upd_pc,
    input  logic [XLEN-1:0]             upd_target,
    input  logic                        upd_taken,
    output logic                        upd_ready,
    input  logic                        flush_req,
    output logic                        flush_busy,
    output logic                        branchPredict_en,
    output logic [XLEN-1:0]             PC,
    output logic                        branchRecover_en,
    output logic [XLEN-1:0]             wr_target,
    output logic                        wr_taken,
    output logic                        inval_en,
    output logic [$clog2(ENTRIES)-1:0]  inval_idx
`ifdef BTB_ACCESS_STAT_EN
    ,
    output logic [XLEN-1:0]             stat_lookups,
    output logic [XLEN-1:0]             stat_updates,
    output logic [XLEN-1:0]             stat_stalls
`endif
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned CNT_W  = $clog2(UPD_DEPTH) + 1;
    localparam int unsigned STRV_W = $clog2(MAX_WAIT + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [STRV_W-1:0]   starve_q, starve_d;

    logic                fifo_push, fifo_pop, fifo_clear;
    logic [CNT_W-1:0]    fifo_count;
    btb_upd_t            fifo_head, fifo_in;
    logic                fifo_nonempty;

    assign fifo_in       = '{pc: upd_pc, target: upd_target, taken: upd_taken};
    assign fifo_nonempty = (fifo_count != '0);

    btb_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            idx_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            starve_q <= starve_d;
        end
    end

    // Outputs are forced to their idle values while reset is held so the
    // btb sees no strobe during reset regardless of request inputs.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        starve_d         = starve_q;
        fetch_ready      = 1'b0;
        upd_ready        = 1'b0;
        flush_busy       = 1'b0;
        branchPredict_en = 1'b0;
        PC               = '0;
        branchRecover_en = 1'b0;
        wr_target        = '0;
        wr_taken         = 1'b0;
        inval_en         = 1'b0;
        inval_idx        = '0;
        fifo_push        = 1'b0;
        fifo_pop         = 1'b0;
        fifo_clear       = 1'b0;

        if (reset) begin
            upd_ready = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    upd_ready = (fifo_count < CNT_W'(UPD_DEPTH));
                    if (!upd_ready || starve_q == STRV_W'(MAX_WAIT)) begin
                        fifo_pop = 1'b1;
                    end else if (fetch_valid) begin
                        branchPredict_en = 1'b1;
                        fetch_ready      = 1'b1;
                        PC               = fetch_pc;
                    end else if (fifo_nonempty) begin
                        fifo_pop = 1'b1;
                    end

                    if (fifo_pop) begin
                        branchRecover_en = 1'b1;
                        PC               = fifo_head.pc;
                        wr_target        = fifo_head.target;
                        wr_taken         = fifo_head.taken;
                        starve_d         = '0;
                    end else if (fifo_nonempty && starve_q != STRV_W'(MAX_WAIT)) begin
                        starve_d = starve_q + 1'b1;
                    end

                    fifo_push = upd_valid && upd_ready && !flush_req;

                    // The current grant still executes; the queue is
                    // discarded on entry to the walk.
                    if (flush_req) begin
                        state_d    = FLUSH;
                        idx_d      = '0;
                        starve_d   = '0;
                        fifo_clear = 1'b1;
                    end
                end
                FLUSH: begin
                    flush_busy = 1'b1;
                    inval_en   = 1'b1;
                    inval_idx  = idx_q;
                    if (flush_req) begin
                        idx_d = '0;
                    end else if (idx_q == IDX_W'(ENTRIES - 1)) begin
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef BTB_ACCESS_STAT_EN
    logic [XLEN-1:0] lookups_q, updates_q, stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lookups_q <= '0;
            updates_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (branchPredict_en)            lookups_q <= lookups_q + 1'b1;
            if (fifo_pop)                    updates_q <= updates_q + 1'b1;
            if (fetch_valid && !fetch_ready) stalls_q  <= stalls_q + 1'b1;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_updates = updates_q;
    assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_btb_access_ctrl.sv
module tb_btb_access_ctrl;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ENTRIES   = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned UPD_DEPTH = 4;
    localparam int unsigned MAX_WAIT  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_valid;
    logic [XLEN-1:0]   fetch_pc;
    logic              fetch_ready;
    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic [XLEN-1:0]   upd_target;
    logic              upd_taken;
    logic              upd_ready;
    logic              flush_req;
    logic              flush_busy;
    logic              branchPredict_en;
    logic [XLEN-1:0]   PC;
    logic              branchRecover_en;
    logic [XLEN-1:0]   wr_target;
    logic              wr_taken;
    logic              inval_en;
    logic [IDX_W-1:0]  inval_idx;
`ifdef BTB_ACCESS_STAT_EN
    logic [XLEN-1:0]   stat_lookups, stat_updates, stat_stalls;
`endif

    btb_access_ctrl #(
        .XLEN      (XLEN),
        .ENTRIES   (ENTRIES),
        .UPD_DEPTH (UPD_DEPTH),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_ready      (fetch_ready),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .upd_ready        (upd_ready),
        .flush_req        (flush_req),
        .flush_busy       (flush_busy),
        .branchPredict_en (branchPredict_en),
        .PC               (PC),
        .branchRecover_en (branchRecover_en),
        .wr_target        (wr_target),
        .wr_taken         (wr_taken),
        .inval_en         (inval_en),
        .inval_idx        (inval_idx)
`ifdef BTB_ACCESS_STAT_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_updates     (stat_updates),
        .stat_stalls      (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
    } upd_s;

    upd_s            mq[$];
    bit              m_flush = 0;
    int              m_idx = 0;
    int              m_starve = 0;
    bit              m_init = 0;
    logic [XLEN-1:0] m_lk, m_up, m_st;

    logic            e_fr, e_ur, e_fb, e_bp, e_br, e_wk, e_ie;
    logic [XLEN-1:0] e_pc, e_wt;
    int              e_ii;
    int              n;
    bit              popped;
    upd_s            h, nu;

    always @(negedge clk) begin
`ifdef BTB_ACCESS_STAT_EN
        if (m_init) begin
            chk("stat_lookups", stat_lookups, m_lk);
            chk("stat_updates", stat_updates, m_up);
            chk("stat_stalls",  stat_stalls,  m_st);
        end
`endif
        e_fr = 0; e_ur = 0; e_fb = 0; e_bp = 0; e_br = 0; e_wk = 0; e_ie = 0;
        e_pc = '0; e_wt = '0; e_ii = 0; popped = 0;

        if (reset) begin
            e_ur = 1;
            mq.delete();
            m_flush = 0; m_idx = 0; m_starve = 0;
            m_lk = '0; m_up = '0; m_st = '0;
            m_init = 1;
        end else if (m_flush) begin
            e_fb = 1; e_ie = 1; e_ii = m_idx;
            if (fetch_valid) m_st = m_st + 1;
            if (flush_req) m_idx = 0;
            else if (m_idx == ENTRIES - 1) begin m_flush = 0; m_idx = 0; end
            else m_idx++;
        end else begin
            n = mq.size();
            e_ur = (n < UPD_DEPTH);
            if (n == UPD_DEPTH || (n > 0 && m_starve >= MAX_WAIT)) popped = 1;
            else if (fetch_valid) begin e_bp = 1; e_fr = 1; e_pc = fetch_pc; end
            else if (n > 0) popped = 1;
            if (popped) begin
                h = mq.pop_front();
                e_br = 1; e_pc = h.pc; e_wt = h.target; e_wk = h.taken;
                m_up = m_up + 1;
                m_starve = 0;
            end else if (n > 0 && m_starve < MAX_WAIT) begin
                m_starve++;
            end
            if (e_bp) m_lk = m_lk + 1;
            if (fetch_valid && !e_fr) m_st = m_st + 1;
            if (flush_req) begin
                mq.delete();
                m_starve = 0; m_flush = 1; m_idx = 0;
            end else if (upd_valid && n < UPD_DEPTH) begin
                nu.pc = upd_pc; nu.target = upd_target; nu.taken = upd_taken;
                mq.push_back(nu);
            end
        end

        chk("fetch_ready",      fetch_ready,      e_fr);
        chk("upd_ready",        upd_ready,        e_ur);
        chk("flush_busy",       flush_busy,       e_fb);
        chk("branchPredict_en", branchPredict_en, e_bp);
        chk("PC",               PC,               e_pc);
        chk("branchRecover_en", branchRecover_en, e_br);
        chk("wr_target",        wr_target,        e_wt);
        chk("wr_taken",         wr_taken,         e_wk);
        chk("inval_en",         inval_en,         e_ie);
        chk("inval_idx",        inval_idx,        e_ii);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [XLEN-1:0] pc);
        upd_valid  = v;
        upd_pc     = pc;
        upd_target = pc + 32'h1000;
        upd_taken  = pc[2];
    endtask

    initial begin
        reset = 1; fetch_valid = 0; fetch_pc = '0; flush_req = 0;
        set_upd(0, '0);
        step(); step();
        #1 chk("lit_reset_upd_ready", upd_ready, 1);
        chk("lit_reset_fetch_ready", fetch_ready, 0);

        // first lookup after reset
        reset = 0; fetch_valid = 1; fetch_pc = 32'h4;
        #1 chk("lit_lookup_bp", branchPredict_en, 1);
        chk("lit_lookup_pc", PC, 32'h4);
        chk("lit_lookup_fr", fetch_ready, 1);
        chk("lit_lookup_ur", upd_ready, 1);
        step();

        // fill the FIFO while fetch keeps the port
        for (int i = 0; i < 4; i++) begin
            set_upd(1, 32'h10 + 32'(4 * i));
            #1 chk("lit_fill_ready", upd_ready, 1);
            step();
        end
        set_upd(0, '0);
        #1 chk("lit_full_ur", upd_ready, 0);
        chk("lit_full_fr", fetch_ready, 0);
        chk("lit_full_br", branchRecover_en, 1);
        chk("lit_full_pc", PC, 32'h10);
        step();
        fetch_valid = 0;
        repeat (4) step();

        // starvation forcing
        fetch_valid = 1; fetch_pc = 32'h88;
        set_upd(1, 32'h40);
        step();
        set_upd(0, '0);
        for (int i = 0; i < 8; i++) begin
            #1 chk("lit_starve_wait", branchRecover_en, 0);
            step();
        end
        #1 chk("lit_starve_br", branchRecover_en, 1);
        chk("lit_starve_fr", fetch_ready, 0);
        chk("lit_starve_pc", PC, 32'h40);
        step();
        #1 chk("lit_starve_after_fr", fetch_ready, 1);
        chk("lit_starve_after_br", branchRecover_en, 0);
        step();

        // push and pop in the same cycle with 3 queued, across pointer wrap
        for (int i = 0; i < 3; i++) begin
            set_upd(1, 32'h50 + 32'(4 * i));
            step();
        end
        fetch_valid = 0;
        set_upd(1, 32'h5C);
        #1 chk("lit_pp_pc0", PC, 32'h50);
        chk("lit_pp_ur", upd_ready, 1);
        step();
        set_upd(1, 32'h60);
        #1 chk("lit_pp_pc1", PC, 32'h54);
        step();
        set_upd(0, '0);
        #1 chk("lit_pp_pc2", PC, 32'h58);
        step();
        repeat (4) step();

        // flush with two updates queued
        fetch_valid = 1;
        set_upd(1, 32'h70); step();
        set_upd(1, 32'h74); step();
        set_upd(1, 32'h78); flush_req = 1;
        #1 chk("lit_flush_grant", fetch_ready, 1);
        step();
        set_upd(0, '0); flush_req = 0;
        for (int i = 0; i < 16; i++) begin
            #1 chk("lit_walk_busy", flush_busy, 1);
            chk("lit_walk_idx", inval_idx, 32'(i));
            chk("lit_walk_fr", fetch_ready, 0);
            step();
        end
        fetch_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("lit_post_busy", flush_busy, 0);
            chk("lit_post_br", branchRecover_en, 0);
            step();
        end

        // reset in the middle of a walk
        flush_req = 1; step();
        flush_req = 0; repeat (5) step();
        #1 chk("lit_mid_idx", inval_idx, 5);
        reset = 1; step();
        reset = 0; fetch_valid = 1; fetch_pc = 32'h200;
        #1 chk("lit_mid_busy", flush_busy, 0);
        chk("lit_mid_inval", inval_en, 0);
        chk("lit_mid_fr", fetch_ready, 1);
        chk("lit_mid_ur", upd_ready, 1);
        step();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            fetch_valid = ($urandom_range(99) < 60);
            fetch_pc    = $urandom() & 32'hFFFF_FFFC;
            upd_valid   = ($urandom_range(99) < 50);
            upd_pc      = $urandom() & 32'hFFFF_FFFC;
            upd_target  = $urandom();
            upd_taken   = $urandom_range(1);
            flush_req   = ($urandom_range(99) < 2);
            reset       = ($urandom_range(999) < 5);
            step();
        end
        reset = 0; fetch_valid = 0; upd_valid = 0; flush_req = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
